char_state_handler: RTL and testbench

Per-character action state machine. Converts debounced player buttons into the 4-bit character state consumed by `char_pos_handler` (movement) and by the sprite/hitbox logic (attack phases). Attack phases last fixed, parameterised numbers of game frames. All decisions advance only on a one-cycle `frame_tick` enable.

---
 rtl/char_pkg.sv | 30 +++
 rtl/attack_phase_timer.sv | 28 ++
 rtl/char_state_handler.sv | 102 ++++++++++
 tb/tb_char_state_handler.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/char_pkg.sv
// Shared character-state encoding and phase-counter width. Position and
// sprite logic import these rather than redefining the codes.
package char_pkg;

  localparam int CNT_W = 5;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE                = 4'd0;
  localparam state_t S_LEFT                = 4'd1;
  localparam state_t S_RIGHT               = 4'd2;
  localparam state_t S_ATTACK_START        = 4'd3;
  localparam state_t S_ATTACK_ACTIVE       = 4'd4;
  localparam state_t S_ATTACK_RECOVERY     = 4'd5;
  localparam state_t S_ATTACK_DIR_START    = 4'd6;
  localparam state_t S_ATTACK_DIR_ACTIVE   = 4'd7;
  localparam state_t S_ATTACK_DIR_RECOVERY = 4'd8;

  // Movement decision; atk_edge is forced low by the caller on recovery exit.
  function automatic state_t move_next(input logic left, input logic right,
                                       input logic atk_edge);
    state_t s;
    s = S_IDLE;
    if (atk_edge)            s = (left ^ right) ? S_ATTACK_DIR_START : S_ATTACK_START;
    else if (left && !right) s = S_LEFT;
    else if (right && !left) s = S_RIGHT;
    return s;
  endfunction

endpackage

// File: rtl/attack_phase_timer.sv
// Counts ticks within one attack phase; done fires on the last tick of a
// phase of length len.
module attack_phase_timer
  import char_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (tick) cnt_d = load ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign done = tick && (cnt_q == len - CNT_W'(1));

endmodule

// File: rtl/char_state_handler.sv
// Per-character action FSM: movement from held buttons, fixed-length
// neutral/directional attack phases, all advancing on frame_tick.
module char_state_handler
  import char_pkg::*;
#(
  parameter int START_FRAMES        = 5,
  parameter int ACTIVE_FRAMES       = 2,
  parameter int RECOVERY_FRAMES     = 16,
  parameter int DIR_START_FRAMES    = 4,
  parameter int DIR_ACTIVE_FRAMES   = 3,
  parameter int DIR_RECOVERY_FRAMES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  output logic [3:0] state,
  output logic       hitbox_en,
  output logic       busy
);

  if (START_FRAMES < 1 || START_FRAMES > 31 ||
      ACTIVE_FRAMES < 1 || ACTIVE_FRAMES > 31 ||
      RECOVERY_FRAMES < 1 || RECOVERY_FRAMES > 31 ||
      DIR_START_FRAMES < 1 || DIR_START_FRAMES > 31 ||
      DIR_ACTIVE_FRAMES < 1 || DIR_ACTIVE_FRAMES > 31 ||
      DIR_RECOVERY_FRAMES < 1 || DIR_RECOVERY_FRAMES > 31) begin : g_bad_len
    $error("char_state_handler: phase lengths must be 1..31");
  end

  state_t           state_q, state_d;
  logic             atk_prev_q, atk_prev_d;
  logic             atk_edge, phase_done, phase_load;
  logic [CNT_W-1:0] phase_len;

  assign atk_edge   = btn_attack & ~atk_prev_q;
  assign atk_prev_d = frame_tick ? btn_attack : atk_prev_q;
  // Any state change is a phase entry, so the counter restarts at 0.
  assign phase_load = (state_d != state_q);

  always_comb begin
    phase_len = CNT_W'(1);
    case (state_q)
      S_ATTACK_START:        phase_len = CNT_W'(START_FRAMES);
      S_ATTACK_ACTIVE:       phase_len = CNT_W'(ACTIVE_FRAMES);
      S_ATTACK_RECOVERY:     phase_len = CNT_W'(RECOVERY_FRAMES);
      S_ATTACK_DIR_START:    phase_len = CNT_W'(DIR_START_FRAMES);
      S_ATTACK_DIR_ACTIVE:   phase_len = CNT_W'(DIR_ACTIVE_FRAMES);
      S_ATTACK_DIR_RECOVERY: phase_len = CNT_W'(DIR_RECOVERY_FRAMES);
      default:               phase_len = CNT_W'(1);
    endcase
  end

  attack_phase_timer u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (frame_tick),
    .load (phase_load),
    .len  (phase_len),
    .done (phase_done)
  );

  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      case (state_q)
        S_IDLE, S_LEFT, S_RIGHT:
          state_d = move_next(btn_left, btn_right, atk_edge);
        S_ATTACK_START:
          if (phase_done) state_d = S_ATTACK_ACTIVE;
        S_ATTACK_ACTIVE:
          if (phase_done) state_d = S_ATTACK_RECOVERY;
        S_ATTACK_DIR_START:
          if (phase_done) state_d = S_ATTACK_DIR_ACTIVE;
        S_ATTACK_DIR_ACTIVE:
          if (phase_done) state_d = S_ATTACK_DIR_RECOVERY;
        S_ATTACK_RECOVERY, S_ATTACK_DIR_RECOVERY:
          if (phase_done) state_d = move_next(btn_left, btn_right, 1'b0);
        default:
          state_d = S_IDLE;
      endcase
    end
  end

  // atk_prev resets high so a button held through reset never fires.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      atk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      atk_prev_q <= atk_prev_d;
    end
  end

  assign state     = state_q;
  assign hitbox_en = (state_q == S_ATTACK_ACTIVE) || (state_q == S_ATTACK_DIR_ACTIVE);
  assign busy      = (state_q >= S_ATTACK_START) && (state_q <= S_ATTACK_DIR_RECOVERY);

endmodule

// File: tb/tb_char_state_handler.sv
// Directed scoreboard bench: the driver queues the state expected after each
// clock edge; the monitor pops and compares state, hitbox_en and busy.
module tb_char_state_handler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_attack = 1'b0;
  logic [3:0] state;
  logic       hitbox_en, busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  char_state_handler dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_attack (btn_attack),
    .state      (state),
    .hitbox_en  (hitbox_en),
    .busy       (busy)
  );

  // Monitor: one expectation per clock edge, sampled 1 time unit after it.
  always @(posedge clk) begin
    logic [3:0] e;
    logic       e_hit, e_busy;
    #1;
    if (exp_q.size() > 0) begin
      e      = exp_q.pop_front();
      e_hit  = (e == 4'd4) || (e == 4'd7);
      e_busy = (e >= 4'd3) && (e <= 4'd8);
      checks = checks + 3;
      if (state !== e) begin
        errors++;
        $display("FAIL state t=%0t got %0d want %0d", $time, state, e);
      end
      if (hitbox_en !== e_hit) begin
        errors++;
        $display("FAIL hitbox_en t=%0t got %0b want %0b", $time, hitbox_en, e_hit);
      end
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL busy t=%0t got %0b want %0b", $time, busy, e_busy);
      end
    end
  end

  task automatic step(input logic r_n, input logic tk, input logic l,
                      input logic r, input logic a, input logic [3:0] s);
    @(negedge clk);
    rst = r_n; frame_tick = tk; btn_left = l; btn_right = r; btn_attack = a;
    exp_q.push_back(s);
  endtask

  task automatic hold(input int n, input logic l, input logic r,
                      input logic a, input logic [3:0] s);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, l, r, a, s);
  endtask

  // One tick followed by three idle cycles; state must not move in between.
  task automatic gstep(input logic l, input logic r, input logic a,
                       input logic [3:0] s);
    step(1'b1, 1'b1, l, r, a, s);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, l, r, a, s);
  endtask

  initial begin
    // Reset with attack held, then release reset still holding attack.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    hold(3, 1'b0, 1'b0, 1'b1, 4'd0);
    hold(1, 1'b0, 1'b0, 1'b0, 4'd0);
    // Re-press fires a neutral attack; holding attack does not retrigger.
    hold(1, 1'b0, 1'b0, 1'b1, 4'd3);
    hold(4, 1'b0, 1'b0, 1'b1, 4'd3);
    hold(2, 1'b0, 1'b0, 1'b1, 4'd4);
    hold(16, 1'b0, 1'b0, 1'b1, 4'd5);
    hold(1, 1'b0, 1'b0, 1'b1, 4'd0);
    hold(1, 1'b0, 1'b0, 1'b0, 4'd0);

    // Right held 3 ticks, then released.
    hold(3, 1'b0, 1'b1, 1'b0, 4'd2);
    hold(1, 1'b0, 1'b0, 1'b0, 4'd0);

    // Single-tick attack pulse: 5 + 2 + 16 busy ticks.
    hold(1, 1'b0, 1'b0, 1'b1, 4'd3);
    hold(4, 1'b0, 1'b0, 1'b0, 4'd3);
    hold(2, 1'b0, 1'b0, 1'b0, 4'd4);
    hold(16, 1'b0, 1'b0, 1'b0, 4'd5);
    hold(1, 1'b0, 1'b0, 1'b0, 4'd0);

    // Directional attack with left held, exits to LEFT.
    hold(1, 1'b1, 1'b0, 1'b0, 4'd1);
    hold(1, 1'b1, 1'b0, 1'b1, 4'd6);
    hold(3, 1'b1, 1'b0, 1'b0, 4'd6);
    hold(3, 1'b1, 1'b0, 1'b0, 4'd7);
    hold(15, 1'b1, 1'b0, 1'b0, 4'd8);
    hold(1, 1'b1, 1'b0, 1'b0, 4'd1);
    hold(1, 1'b0, 1'b0, 1'b0, 4'd0);

    // Re-press during ACTIVE and on the recovery-exit tick: no restart.
    hold(1, 1'b0, 1'b0, 1'b1, 4'd3);
    hold(4, 1'b0, 1'b0, 1'b0, 4'd3);
    hold(1, 1'b0, 1'b0, 1'b0, 4'd4);
    hold(1, 1'b0, 1'b0, 1'b1, 4'd4);
    hold(1, 1'b0, 1'b0, 1'b0, 4'd5);
    hold(15, 1'b0, 1'b0, 1'b0, 4'd5);
    hold(1, 1'b0, 1'b0, 1'b1, 4'd0);
    hold(1, 1'b0, 1'b0, 1'b1, 4'd0);
    hold(1, 1'b0, 1'b0, 1'b0, 4'd0);

    // Gated ticks: attack, then reset on the first ACTIVE tick.
    gstep(1'b0, 1'b0, 1'b1, 4'd3);
    for (int i = 0; i < 4; i++) gstep(1'b0, 1'b0, 1'b0, 4'd3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) gstep(1'b1, 1'b1, 1'b0, 4'd0);
    // Fresh press after reset still works.
    gstep(1'b0, 1'b0, 1'b1, 4'd3);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
